// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcodes, immediate formats and source-use decode for the decode stage
package decode_pkg;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    function automatic imm_type_e imm_type(input logic [6:0] opcode);
        case (opcode)
            LOAD, OP_IMM, JALR: return IMM_I;
            STORE:              return IMM_S;
            BRANCH:             return IMM_B;
            LUI, AUIPC:         return IMM_U;
            JAL:                return IMM_J;
            default:            return IMM_NONE;
        endcase
    endfunction

    // Returns {use_rs1, use_rs2}
    function automatic logic [1:0] src_use(input logic [6:0] opcode);
        case (opcode)
            OP, STORE, BRANCH:  return 2'b11;
            LOAD, OP_IMM, JALR: return 2'b10;
            default:            return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - RV32I immediate extraction, purely combinational
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:0] inst,
    input  imm_type_e   sel,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (sel)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'b0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_regfile_sb.sv
// rtl/decode_regfile_sb.sv - decode stage: 2R/2W register file, immediate generator, load scoreboard
module decode_regfile_sb
    import decode_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter int              INIT_IDX = 31,
    parameter logic [XLEN-1:0] INIT_VAL = 32'hFFFFFC00,
    parameter int              BYPASS   = 1,
    localparam int             RW       = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst,
    input  logic            issue_valid,
    output logic            issue_ready,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] imm32,
    input  logic            alu_wb_valid,
    input  logic [RW-1:0]   alu_wb_rd,
    input  logic [XLEN-1:0] alu_wb_data,
    input  logic            mem_wb_valid,
    input  logic [RW-1:0]   mem_wb_rd,
    input  logic [XLEN-1:0] mem_wb_data,
    output logic [RW:0]     pending_cnt,
    output logic            sb_err
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_nxt;
    logic [RW:0]      cnt_nxt;
    logic [6:0]       opcode;
    logic [RW-1:0]    rs1_idx;
    logic [RW-1:0]    rs2_idx;
    logic [RW-1:0]    rd_idx;
    logic [1:0]       use_src;
    logic [31:0]      imm_raw;
    logic             mem_hit1, mem_hit2, alu_hit1, alu_hit2;
    logic             haz1, haz2;
    logic             ld_set, mem_clr, alu_wr;
    logic             err_now;

    assign opcode  = inst[6:0];
    assign rs1_idx = inst[15 +: RW];
    assign rs2_idx = inst[20 +: RW];
    assign rd_idx  = inst[7 +: RW];
    assign use_src = src_use(opcode);

    imm_gen u_imm_gen (
        .inst (inst),
        .sel  (imm_type(opcode)),
        .imm  (imm_raw)
    );

    assign imm32 = XLEN'($signed(imm_raw));

    // Same-cycle forwarding; the load return outranks the ALU result
    assign mem_hit1 = (BYPASS != 0) && mem_wb_valid && (mem_wb_rd == rs1_idx);
    assign mem_hit2 = (BYPASS != 0) && mem_wb_valid && (mem_wb_rd == rs2_idx);
    assign alu_hit1 = (BYPASS != 0) && alu_wb_valid && (alu_wb_rd == rs1_idx);
    assign alu_hit2 = (BYPASS != 0) && alu_wb_valid && (alu_wb_rd == rs2_idx);

    assign rs1_data = (rs1_idx == '0) ? '0 : mem_hit1 ? mem_wb_data
                    : alu_hit1 ? alu_wb_data : regs[rs1_idx];
    assign rs2_data = (rs2_idx == '0) ? '0 : mem_hit2 ? mem_wb_data
                    : alu_hit2 ? alu_wb_data : regs[rs2_idx];

    assign haz1 = use_src[1] && (rs1_idx != '0) && pending[rs1_idx] && !mem_hit1;
    assign haz2 = use_src[0] && (rs2_idx != '0) && pending[rs2_idx] && !mem_hit2;
    assign issue_ready = rst || !(haz1 || haz2);

    assign ld_set  = issue_valid && issue_ready && (opcode == LOAD) && (rd_idx != '0);
    assign mem_clr = mem_wb_valid && (mem_wb_rd != '0);
    assign alu_wr  = alu_wb_valid && (alu_wb_rd != '0);

    // A load issued onto the rd being returned this cycle is a legal re-use, not an error
    assign err_now = (mem_clr && !pending[mem_wb_rd])
                  || (alu_wr && pending[alu_wb_rd])
                  || (ld_set && pending[rd_idx] && !(mem_clr && (mem_wb_rd == rd_idx)))
                  || (alu_wr && mem_clr && (alu_wb_rd == mem_wb_rd));

    always_comb begin
        pending_nxt = pending;
        if (mem_clr) pending_nxt[mem_wb_rd] = 1'b0;
        if (ld_set)  pending_nxt[rd_idx]    = 1'b1;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_nxt = cnt_nxt + {{RW{1'b0}}, pending_nxt[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (i == INIT_IDX) ? INIT_VAL : '0;
            end
            pending     <= '0;
            pending_cnt <= '0;
            sb_err      <= 1'b0;
        end else begin
            if (alu_wr)  regs[alu_wb_rd] <= alu_wb_data;
            if (mem_clr) regs[mem_wb_rd] <= mem_wb_data;
            pending     <= pending_nxt;
            pending_cnt <= cnt_nxt;
            if (err_now) sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_regfile_sb.sv
// tb/tb_decode_regfile_sb.sv - directed self-checking bench for decode_regfile_sb
module tb_decode_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] rs1_data, rs2_data, imm32;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        mem_wb_valid;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_data;
    logic [5:0]  pending_cnt;
    logic        sb_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] imm;
    } imm_vec_t;

    imm_vec_t vecs[11];

    always #5 clk = ~clk;

    decode_regfile_sb dut (
        .clk          (clk),
        .rst          (rst),
        .inst         (inst),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .imm32        (imm32),
        .alu_wb_valid (alu_wb_valid),
        .alu_wb_rd    (alu_wb_rd),
        .alu_wb_data  (alu_wb_data),
        .mem_wb_valid (mem_wb_valid),
        .mem_wb_rd    (mem_wb_rd),
        .mem_wb_data  (mem_wb_data),
        .pending_cnt  (pending_cnt),
        .sb_err       (sb_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
    endfunction

    initial begin
        rst = 1'b1; inst = '0; issue_valid = 1'b0;
        alu_wb_valid = 1'b0; alu_wb_rd = '0; alu_wb_data = '0;
        mem_wb_valid = 1'b0; mem_wb_rd = '0; mem_wb_data = '0;

        vecs[0]  = '{"beq_x0_x0_m4", 32'hFE000EE3, 32'hFFFFFFFC};
        vecs[1]  = '{"beq_p16",      32'h00208863, 32'h00000010};
        vecs[2]  = '{"jal_p8",       32'h0080006F, 32'h00000008};
        vecs[3]  = '{"jal_m8",       32'hFF9FF06F, 32'hFFFFFFF8};
        vecs[4]  = '{"lui",          32'h12345037, 32'h12345000};
        vecs[5]  = '{"auipc",        32'h00001017, 32'h00001000};
        vecs[6]  = '{"addi_m1",      32'hFFF00093, 32'hFFFFFFFF};
        vecs[7]  = '{"lw_m1",        32'hFFF0A183, 32'hFFFFFFFF};
        vecs[8]  = '{"sw_m4",        32'hFE112E23, 32'hFFFFFFFC};
        vecs[9]  = '{"jalr_p8",      32'h00808067, 32'h00000008};
        vecs[10] = '{"unknown_op",   32'hFFFFFFFF, 32'h00000000};

        #1;
        chk("ready_in_reset", {31'd0, issue_ready}, 32'd1);
        cyc();
        rst = 1'b0;
        inst = r_add(5'd0, 5'd31, 5'd5);
        #1;
        chk("reset_x31", rs1_data, 32'hFFFFFC00);
        chk("reset_x5", rs2_data, 32'h0);
        chk("reset_cnt", {26'd0, pending_cnt}, 32'd0);
        chk("reset_err", {31'd0, sb_err}, 32'd0);
        chk("reset_ready", {31'd0, issue_ready}, 32'd1);

        for (int i = 0; i < 11; i++) begin
            inst = vecs[i].inst;
            #1;
            chk({"imm_", vecs[i].name}, imm32, vecs[i].imm);
            chk({"rdy_", vecs[i].name}, {31'd0, issue_ready}, 32'd1);
        end

        // x0 is hardwired; x7 is forwarded then stored
        inst = r_add(5'd0, 5'd0, 5'd0);
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd0; alu_wb_data = 32'h1234;
        cyc();
        alu_wb_valid = 1'b0;
        #1;
        chk("x0_reads_zero", rs1_data, 32'h0);
        inst = r_add(5'd0, 5'd7, 5'd0);
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd7; alu_wb_data = 32'd5;
        #1;
        chk("x7_bypass", rs1_data, 32'd5);
        cyc();
        alu_wb_valid = 1'b0;
        #1;
        chk("x7_stored", rs1_data, 32'd5);

        // lw x3 then dependent add stalls until the load returns
        inst = 32'h0000A183; issue_valid = 1'b1;
        #1;
        chk("lw_ready", {31'd0, issue_ready}, 32'd1);
        cyc();
        inst = r_add(5'd4, 5'd3, 5'd3);
        #1;
        chk("add_stall", {31'd0, issue_ready}, 32'd0);
        chk("cnt_one", {26'd0, pending_cnt}, 32'd1);
        cyc();
        chk("add_stall_hold", {31'd0, issue_ready}, 32'd0);
        mem_wb_valid = 1'b1; mem_wb_rd = 5'd3; mem_wb_data = 32'hDEAD;
        #1;
        chk("add_release", {31'd0, issue_ready}, 32'd1);
        chk("fwd_rs1_dead", rs1_data, 32'hDEAD);
        chk("fwd_rs2_dead", rs2_data, 32'hDEAD);
        cyc();
        mem_wb_valid = 1'b0; issue_valid = 1'b0;
        #1;
        chk("cnt_cleared", {26'd0, pending_cnt}, 32'd0);
        chk("x3_stored", rs1_data, 32'hDEAD);
        chk("no_err_load", {31'd0, sb_err}, 32'd0);

        // New load on x3 in the same cycle the older x3 load returns
        inst = 32'h0000A183; issue_valid = 1'b1;
        cyc();
        mem_wb_valid = 1'b1; mem_wb_rd = 5'd3; mem_wb_data = 32'h1;
        #1;
        chk("reissue_ready", {31'd0, issue_ready}, 32'd1);
        cyc();
        mem_wb_valid = 1'b0; issue_valid = 1'b0;
        inst = r_add(5'd4, 5'd3, 5'd3);
        #1;
        chk("reissue_cnt", {26'd0, pending_cnt}, 32'd1);
        chk("reissue_err", {31'd0, sb_err}, 32'd0);
        chk("reissue_still_pending", {31'd0, issue_ready}, 32'd0);
        inst = 32'h0000A283; issue_valid = 1'b1;
        cyc();
        issue_valid = 1'b0;
        chk("cnt_two", {26'd0, pending_cnt}, 32'd2);
        mem_wb_valid = 1'b1; mem_wb_rd = 5'd3; mem_wb_data = 32'h7;
        cyc();
        mem_wb_rd = 5'd5; mem_wb_data = 32'h8;
        cyc();
        mem_wb_valid = 1'b0;
        chk("cnt_drained", {26'd0, pending_cnt}, 32'd0);
        chk("drain_err", {31'd0, sb_err}, 32'd0);

        // Dual write to x9: mem wins, error is sticky until reset
        inst = r_add(5'd0, 5'd9, 5'd0);
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd9; alu_wb_data = 32'd1;
        mem_wb_valid = 1'b1; mem_wb_rd = 5'd9; mem_wb_data = 32'd2;
        #1;
        chk("dual_bypass_prio", rs1_data, 32'd2);
        cyc();
        alu_wb_valid = 1'b0; mem_wb_valid = 1'b0;
        #1;
        chk("dual_x9", rs1_data, 32'd2);
        chk("dual_err", {31'd0, sb_err}, 32'd1);
        repeat (3) cyc();
        chk("err_sticky", {31'd0, sb_err}, 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("err_cleared", {31'd0, sb_err}, 32'd0);

        // ALU write to a register with a load outstanding
        inst = 32'h0000A303; issue_valid = 1'b1;
        cyc();
        issue_valid = 1'b0;
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd6; alu_wb_data = 32'h3;
        cyc();
        alu_wb_valid = 1'b0;
        chk("alu_pending_err", {31'd0, sb_err}, 32'd1);
        chk("alu_pending_cnt", {26'd0, pending_cnt}, 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;

        // Reset with a load outstanding and a return in the reset cycle
        inst = 32'h0000A183; issue_valid = 1'b1;
        cyc();
        issue_valid = 1'b0;
        chk("mid_cnt", {26'd0, pending_cnt}, 32'd1);
        rst = 1'b1;
        mem_wb_valid = 1'b1; mem_wb_rd = 5'd3; mem_wb_data = 32'h55;
        cyc();
        rst = 1'b0; mem_wb_valid = 1'b0;
        inst = r_add(5'd4, 5'd3, 5'd3);
        #1;
        chk("mid_rst_cnt", {26'd0, pending_cnt}, 32'd0);
        chk("mid_rst_err", {31'd0, sb_err}, 32'd0);
        chk("mid_rst_x3", rs1_data, 32'h0);
        chk("mid_rst_ready", {31'd0, issue_ready}, 32'd1);
        mem_wb_valid = 1'b1; mem_wb_rd = 5'd3; mem_wb_data = 32'h66;
        cyc();
        mem_wb_valid = 1'b0;
        chk("late_return_err", {31'd0, sb_err}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
